// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage.
//   ALUOP_*     : 2-bit ALU operation class carried in ex_ctrl[2:1]
//   FUNCT3_*    : funct3 encodings for the base ALU and for RV32M mul/div
//   OPC_RTYPE   : register-register opcode
//   F7_MULDIV   : funct7 value selecting the RV32M extension
//   md_state_t  : sequencing states of the iterative mul/div unit
package ex_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SLT  = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;
    localparam logic [2:0] FUNCT3_XOR  = 3'b100;
    localparam logic [2:0] FUNCT3_SR   = 3'b101;
    localparam logic [2:0] FUNCT3_OR   = 3'b110;
    localparam logic [2:0] FUNCT3_AND  = 3'b111;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

endpackage

// File: rtl/ex_md_unit.sv
// Iterative RV32M multiply/divide datapath.
//   clk, rst_n     : clock, synchronous active-low reset
//   clear          : discard any operation in flight
//   start          : latch operands/funct3 and begin a new operation
//   step           : perform one shift-add or restoring-subtract iteration
//   funct3         : RV32M operation select (sampled with start)
//   op_a, op_b     : raw (two's complement) operands (sampled with start)
//   special        : start-time flag, divide-by-zero or signed overflow (no iterations needed)
//   last           : the current step is the final (N-th) iteration
//   result         : sign-corrected result, valid once iterations are complete
module md_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         start,
    input  logic         step,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         special,
    output logic         last,
    output logic [N-1:0] result
);
    import ex_pkg::*;

    localparam int CW = $clog2(N);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    // acc: multiply -> {partial product, remaining multiplier bits}
    //      divide   -> {partial remainder, dividend bits / quotient bits}
    logic [2*N-1:0] acc;
    logic [N-1:0]   opnd;
    logic [2:0]     f3;
    logic           neg;
    logic [CW-1:0]  cnt;

    logic           is_div, sgn_a, sgn_b, div_zero, div_ovf;
    logic [N-1:0]   mag_a, mag_b;

    always_comb begin
        // NOTE: every always_comb output gets a value on every path; here each
        // signal is assigned unconditionally, so no latch can be inferred.
        is_div   = funct3[2];
        sgn_a    = op_a[N-1] && (funct3 == FUNCT3_MULH || funct3 == FUNCT3_MULHSU ||
                                 funct3 == FUNCT3_DIV  || funct3 == FUNCT3_REM);
        sgn_b    = op_b[N-1] && (funct3 == FUNCT3_MULH || funct3 == FUNCT3_DIV ||
                                 funct3 == FUNCT3_REM);
        mag_a    = sgn_a ? -op_a : op_a;
        mag_b    = sgn_b ? -op_b : op_b;
        div_zero = is_div && (op_b == '0);
        div_ovf  = (funct3 == FUNCT3_DIV || funct3 == FUNCT3_REM) &&
                   (op_a == MIN_NEG) && (op_b == '1);
    end

    assign special = div_zero || div_ovf;
    assign last    = (cnt == CW'(N - 1));

    // One iteration of each algorithm; sign bit of rem_diff set means the
    // trial subtraction underflowed and the remainder is restored.
    logic [N:0] add_sum, rem_shift, rem_diff;
    assign add_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : '0);
    assign rem_shift = {acc[2*N-1:N], acc[N-1]};
    assign rem_diff  = rem_shift - {1'b0, opnd};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n || clear) begin
            acc  <= '0;
            opnd <= '0;
            f3   <= '0;
            neg  <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            f3  <= funct3;
            cnt <= '0;
            if (div_zero) begin
                // quotient all-ones, remainder = dividend
                acc  <= {op_a, {N{1'b1}}};
                opnd <= op_b;
                neg  <= 1'b0;
            end else if (div_ovf) begin
                // quotient = dividend, remainder 0
                acc  <= {{N{1'b0}}, op_a};
                opnd <= op_b;
                neg  <= 1'b0;
            end else if (is_div) begin
                acc  <= {{N{1'b0}}, mag_a};
                opnd <= mag_b;
                // remainder takes the dividend's sign, quotient the xor of both
                neg  <= (funct3 == FUNCT3_REM) ? sgn_a : (sgn_a ^ sgn_b);
            end else begin
                acc  <= {{N{1'b0}}, mag_b};
                opnd <= mag_a;
                neg  <= sgn_a ^ sgn_b;
            end
        end else if (step) begin
            cnt <= cnt + 1'b1;
            if (f3[2]) begin
                if (!rem_diff[N]) acc <= {rem_diff[N-1:0], acc[N-2:0], 1'b1};
                else              acc <= {rem_shift[N-1:0], acc[N-2:0], 1'b0};
            end else begin
                acc <= {add_sum, acc[N-1:1]};
            end
        end
    end

    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   div_sel;

    always_comb begin
        prod_fix = neg ? -acc : acc;
        div_sel  = f3[1] ? acc[2*N-1:N] : acc[N-1:0];
        if (f3[2])                  result = neg ? -div_sel : div_sel;
        else if (f3 == FUNCT3_MUL)  result = prod_fix[N-1:0];
        else                        result = prod_fix[2*N-1:N];
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative RV32M unit
// sequencing, and the registered EX/MEM boundary.
//   clk, rst_n        : clock, synchronous active-low reset
//   ex_ctrl_i         : {aluop[1:0], alusrc}
//   mem_ctrl_i        : {memread, memwrite, branch}, passed to EX/MEM
//   wb_ctrl_i         : {memtoreg, regwrite}, passed to EX/MEM
//   rs1_i, rs2_i, rd_i: register indices
//   imm_i, instr_i    : immediate and instruction word
//   rs1_data_i/rs2_data_i : register-file read data
//   memwb_*           : MEM/WB destination, regwrite, data (forwarding source)
//   flush_i           : kill the instruction in EX
//   stall_o           : freeze upstream stages this cycle (combinational)
//   mem_ctrl_o, wb_ctrl_o, rd_o, alu_result_o, store_data_o, zero_o : EX/MEM register
module ex_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   ex_ctrl_i,
    input  logic [2:0]   mem_ctrl_i,
    input  logic [1:0]   wb_ctrl_i,
    input  logic [4:0]   rs1_i,
    input  logic [4:0]   rs2_i,
    input  logic [4:0]   rd_i,
    input  logic [N-1:0] imm_i,
    input  logic [N-1:0] instr_i,
    input  logic [N-1:0] rs1_data_i,
    input  logic [N-1:0] rs2_data_i,
    input  logic [4:0]   memwb_rd_i,
    input  logic         memwb_regwrite_i,
    input  logic [N-1:0] memwb_data_i,
    input  logic         flush_i,
    output logic         stall_o,
    output logic [2:0]   mem_ctrl_o,
    output logic [1:0]   wb_ctrl_o,
    output logic [4:0]   rd_o,
    output logic [N-1:0] alu_result_o,
    output logic [N-1:0] store_data_o,
    output logic         zero_o
);
    import ex_pkg::*;

    logic [1:0] aluop;
    logic       alusrc;
    logic [2:0] funct3;
    logic [6:0] funct7, opcode;
    logic       unused_instr_bits;

    assign {aluop, alusrc}   = ex_ctrl_i;
    assign funct3            = instr_i[14:12];
    assign funct7            = instr_i[31:25];
    assign opcode            = instr_i[6:0];
    assign unused_instr_bits = ^{instr_i[24:15], instr_i[11:7]};

    // Forwarding: the younger EX/MEM result wins over MEM/WB; x0 never forwards.
    logic [N-1:0] fwd_a, fwd_b, op_b;
    always_comb begin
        fwd_a = rs1_data_i;
        fwd_b = rs2_data_i;
        if (memwb_regwrite_i && memwb_rd_i != 5'd0 && memwb_rd_i == rs1_i) fwd_a = memwb_data_i;
        if (memwb_regwrite_i && memwb_rd_i != 5'd0 && memwb_rd_i == rs2_i) fwd_b = memwb_data_i;
        if (wb_ctrl_o[0] && rd_o != 5'd0 && rd_o == rs1_i) fwd_a = alu_result_o;
        if (wb_ctrl_o[0] && rd_o != 5'd0 && rd_o == rs2_i) fwd_b = alu_result_o;
    end
    assign op_b = alusrc ? imm_i : fwd_b;

    logic [4:0]   shamt;
    logic [N-1:0] alu_out;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_out = fwd_a + op_b;
        if (aluop == ALUOP_SUB) begin
            alu_out = fwd_a - op_b;
        end else if (aluop == ALUOP_FUNCT) begin
            case (funct3)
                FUNCT3_ADD:  alu_out = (opcode[5] && funct7[5]) ? fwd_a - op_b : fwd_a + op_b;
                FUNCT3_SLL:  alu_out = fwd_a << shamt;
                FUNCT3_SLT:  alu_out = {{(N-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
                FUNCT3_SLTU: alu_out = {{(N-1){1'b0}}, fwd_a < op_b};
                FUNCT3_XOR:  alu_out = fwd_a ^ op_b;
                FUNCT3_SR:   alu_out = funct7[5] ? $unsigned($signed(fwd_a) >>> shamt)
                                                 : fwd_a >> shamt;
                FUNCT3_OR:   alu_out = fwd_a | op_b;
                FUNCT3_AND:  alu_out = fwd_a & op_b;
                default:     alu_out = fwd_a + op_b;
            endcase
        end
    end

    md_state_t    state;
    logic         is_md, md_start, md_step, md_special, md_last;
    logic [N-1:0] md_result;
    logic [2:0]   lat_mem;
    logic [1:0]   lat_wb;
    logic [4:0]   lat_rd;

    assign is_md    = (aluop == ALUOP_FUNCT) && (opcode == OPC_RTYPE) && (funct7 == F7_MULDIV);
    assign md_start = (state == IDLE) && is_md && !flush_i;
    assign md_step  = (state == BUSY) && !flush_i;
    assign stall_o  = rst_n && !flush_i && (((state == IDLE) && is_md) || (state == BUSY));

    md_unit #(.N(N)) u_md (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush_i),
        .start   (md_start),
        .step    (md_step),
        .funct3  (funct3),
        .op_a    (fwd_a),
        .op_b    (fwd_b),
        .special (md_special),
        .last    (md_last),
        .result  (md_result)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            mem_ctrl_o   <= '0;
            wb_ctrl_o    <= '0;
            rd_o         <= '0;
            alu_result_o <= '0;
            store_data_o <= '0;
            zero_o       <= 1'b0;
            lat_mem      <= '0;
            lat_wb       <= '0;
            lat_rd       <= '0;
        end else begin
            // Bubble by default; the branches below override it.
            mem_ctrl_o   <= '0;
            wb_ctrl_o    <= '0;
            rd_o         <= '0;
            alu_result_o <= '0;
            store_data_o <= '0;
            zero_o       <= 1'b0;
            if (flush_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (is_md) begin
                            lat_mem <= mem_ctrl_i;
                            lat_wb  <= wb_ctrl_i;
                            lat_rd  <= rd_i;
                            state   <= md_special ? DONE : BUSY;
                        end else begin
                            mem_ctrl_o   <= mem_ctrl_i;
                            wb_ctrl_o    <= wb_ctrl_i;
                            rd_o         <= rd_i;
                            alu_result_o <= alu_out;
                            store_data_o <= fwd_b;
                            zero_o       <= (alu_out == '0);
                        end
                    end
                    BUSY: begin
                        if (md_last) state <= DONE;
                    end
                    DONE: begin
                        // The frozen md instruction is still presented; it is not re-issued.
                        mem_ctrl_o   <= lat_mem;
                        wb_ctrl_o    <= lat_wb;
                        rd_o         <= lat_rd;
                        alu_result_o <= md_result;
                        zero_o       <= (md_result == '0);
                        state        <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
module tb_ex_stage;
    import ex_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   ex_ctrl_i, mem_ctrl_i;
    logic [1:0]   wb_ctrl_i;
    logic [4:0]   rs1_i, rs2_i, rd_i, memwb_rd_i;
    logic [N-1:0] imm_i, instr_i, rs1_data_i, rs2_data_i, memwb_data_i;
    logic         memwb_regwrite_i, flush_i;
    logic         stall_o, zero_o;
    logic [2:0]   mem_ctrl_o;
    logic [1:0]   wb_ctrl_o;
    logic [4:0]   rd_o;
    logic [N-1:0] alu_result_o, store_data_o;

    int n_checks = 0;
    int n_fail   = 0;

    ex_stage #(.N(N)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_ctrl_i        (ex_ctrl_i),
        .mem_ctrl_i       (mem_ctrl_i),
        .wb_ctrl_i        (wb_ctrl_i),
        .rs1_i            (rs1_i),
        .rs2_i            (rs2_i),
        .rd_i             (rd_i),
        .imm_i            (imm_i),
        .instr_i          (instr_i),
        .rs1_data_i       (rs1_data_i),
        .rs2_data_i       (rs2_data_i),
        .memwb_rd_i       (memwb_rd_i),
        .memwb_regwrite_i (memwb_regwrite_i),
        .memwb_data_i     (memwb_data_i),
        .flush_i          (flush_i),
        .stall_o          (stall_o),
        .mem_ctrl_o       (mem_ctrl_o),
        .wb_ctrl_o        (wb_ctrl_o),
        .rd_o             (rd_o),
        .alu_result_o     (alu_result_o),
        .store_data_o     (store_data_o),
        .zero_o           (zero_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_rtype(input logic [6:0] f7, input logic [2:0] f3,
                             input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                             input logic [31:0] v1, input logic [31:0] v2);
        ex_ctrl_i  = {ALUOP_FUNCT, 1'b0};
        mem_ctrl_i = 3'b000;
        wb_ctrl_i  = 2'b01;
        rs1_i      = s1;
        rs2_i      = s2;
        rd_i       = d;
        imm_i      = '0;
        instr_i    = {f7, s2, s1, f3, d, OPC_RTYPE};
        rs1_data_i = v1;
        rs2_data_i = v2;
    endtask

    task automatic set_itype(input logic [31:0] imm, input logic [4:0] s1, input logic [31:0] v1,
                             input logic [4:0] d, input logic [1:0] wb);
        ex_ctrl_i  = {ALUOP_ADD, 1'b1};
        mem_ctrl_i = 3'b000;
        wb_ctrl_i  = wb;
        rs1_i      = s1;
        rs2_i      = 5'd0;
        rd_i       = d;
        imm_i      = imm;
        instr_i    = {imm[11:0], s1, 3'b000, d, 7'b0010011};
        rs1_data_i = v1;
        rs2_data_i = '0;
    endtask

    task automatic alu_rr(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] exp);
        set_rtype(f7, f3, 5'd5, 5'd6, 5'd7, v1, v2);
        tick();
        check(tag, alu_result_o, exp);
    endtask

    task automatic md_run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d,
                          input logic [31:0] exp, input int exp_stalls);
        int stalls;
        set_rtype(F7_MULDIV, f3, 5'd10, 5'd11, d, a, b);
        #1;
        stalls = 0;
        while (stall_o === 1'b1 && stalls < 100) begin
            stalls++;
            tick();
        end
        check({tag, " stall cycles"}, 32'(stalls), 32'(exp_stalls));
        check({tag, " bubble wb_ctrl"}, {30'd0, wb_ctrl_o}, 32'd0);
        tick();
        check({tag, " result"}, alu_result_o, exp);
        check({tag, " rd"}, {27'd0, rd_o}, {27'd0, d});
        check({tag, " wb_ctrl"}, {30'd0, wb_ctrl_o}, 32'd1);
    endtask

    initial begin
        // ---- reset ----
        rst_n = 1'b0;
        flush_i = 1'b0;
        memwb_rd_i = '0;
        memwb_regwrite_i = 1'b0;
        memwb_data_i = '0;
        set_rtype(7'd0, FUNCT3_ADD, 5'd0, 5'd0, 5'd0, '0, '0);
        tick();
        tick();
        check("reset alu_result", alu_result_o, 32'd0);
        check("reset ctrl", {27'd0, mem_ctrl_o, wb_ctrl_o}, 32'd0);
        check("reset rd/zero/stall", {26'd0, rd_o, zero_o}, 32'd0);
        check("reset stall", {31'd0, stall_o}, 32'd0);
        rst_n = 1'b1;

        // ---- basic ADD ----
        set_rtype(7'd0, FUNCT3_ADD, 5'd5, 5'd6, 5'd2, 32'd5, 32'd7);
        #1;
        check("add stall", {31'd0, stall_o}, 32'd0);
        tick();
        check("add result", alu_result_o, 32'd12);
        check("add zero", {31'd0, zero_o}, 32'd0);
        check("add rd", {27'd0, rd_o}, 32'd2);
        check("add wb_ctrl", {30'd0, wb_ctrl_o}, 32'd1);

        // ---- single-cycle ALU ops ----
        alu_rr("sub zero", 7'h20, FUNCT3_ADD, 32'd9, 32'd9, 32'd0);
        check("sub zero flag", {31'd0, zero_o}, 32'd1);
        alu_rr("sll", 7'h00, FUNCT3_SLL, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000);
        alu_rr("sra", 7'h20, FUNCT3_SR, 32'h8000_0000, 32'd4, 32'hF800_0000);
        alu_rr("srl", 7'h00, FUNCT3_SR, 32'h8000_0000, 32'd4, 32'h0800_0000);
        alu_rr("slt", 7'h00, FUNCT3_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu_rr("sltu", 7'h00, FUNCT3_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu_rr("xor", 7'h00, FUNCT3_XOR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
        alu_rr("and", 7'h00, FUNCT3_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        set_itype(32'd3, 5'd5, 32'd10, 5'd7, 2'b01);
        ex_ctrl_i = {ALUOP_SUB, 1'b1};
        tick();
        check("aluop sub imm", alu_result_o, 32'd7);

        // ---- forwarding ----
        set_itype(32'h10, 5'd0, 32'd0, 5'd1, 2'b01);
        tick();
        check("addi to x1", alu_result_o, 32'h10);
        memwb_rd_i = 5'd1;
        memwb_regwrite_i = 1'b1;
        memwb_data_i = 32'h20;
        set_rtype(7'd0, FUNCT3_ADD, 5'd1, 5'd0, 5'd4, 32'd0, 32'd0);
        tick();
        check("fwd exmem beats memwb", alu_result_o, 32'h10);
        set_itype(32'h10, 5'd0, 32'd0, 5'd1, 2'b00);
        tick();
        set_rtype(7'd0, FUNCT3_ADD, 5'd1, 5'd1, 5'd4, 32'd0, 32'd0);
        tick();
        check("fwd memwb both", alu_result_o, 32'h40);
        check("fwd store data", store_data_o, 32'h20);
        memwb_rd_i = 5'd0;
        memwb_data_i = 32'h77;
        set_itype(32'h55, 5'd0, 32'd0, 5'd0, 2'b01);
        tick();
        set_rtype(7'd0, FUNCT3_ADD, 5'd0, 5'd0, 5'd4, 32'd3, 32'd4);
        tick();
        check("x0 never forwarded", alu_result_o, 32'd7);
        memwb_regwrite_i = 1'b0;

        // ---- multiply / divide ----
        md_run("mul", FUNCT3_MUL, 32'hFFFF_FFFF, 32'd3, 5'd3, 32'hFFFF_FFFD, 33);
        set_rtype(7'd0, FUNCT3_ADD, 5'd3, 5'd0, 5'd7, 32'd0, 32'd5);
        #1;
        check("add after mul stall", {31'd0, stall_o}, 32'd0);
        tick();
        check("add uses fwd product", alu_result_o, 32'd2);
        md_run("mulhu", FUNCT3_MULHU, 32'hFFFF_FFFF, 32'd3, 5'd12, 32'd2, 33);
        md_run("mulh", FUNCT3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'd0, 33);
        check("mulh zero flag", {31'd0, zero_o}, 32'd1);
        md_run("div", FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFD, 33);
        md_run("rem", FUNCT3_REM, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFF, 33);
        md_run("divu by 0", FUNCT3_DIVU, 32'h0000_1234, 32'd0, 5'd12, 32'hFFFF_FFFF, 1);
        md_run("remu by 0", FUNCT3_REMU, 32'h0000_1234, 32'd0, 5'd12, 32'h0000_1234, 1);
        md_run("div ovf", FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1);
        md_run("rem ovf", FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1);

        // ---- flush during BUSY ----
        set_rtype(F7_MULDIV, FUNCT3_DIV, 5'd10, 5'd11, 5'd13, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) tick();
        flush_i = 1'b1;
        #1;
        check("flush stall low", {31'd0, stall_o}, 32'd0);
        tick();
        flush_i = 1'b0;
        check("flush bubble", {27'd0, mem_ctrl_o, wb_ctrl_o}, 32'd0);
        set_rtype(7'd0, FUNCT3_ADD, 5'd5, 5'd6, 5'd7, 32'd1, 32'd2);
        #1;
        check("after flush idle", {31'd0, stall_o}, 32'd0);
        tick();
        check("after flush add", alu_result_o, 32'd3);
        flush_i = 1'b1;
        set_rtype(7'd0, FUNCT3_ADD, 5'd5, 5'd6, 5'd7, 32'd4, 32'd4);
        tick();
        flush_i = 1'b0;
        check("flush alu op wb", {30'd0, wb_ctrl_o}, 32'd0);
        check("flush alu op data", alu_result_o, 32'd0);

        // ---- reset in the middle of a divide ----
        set_rtype(F7_MULDIV, FUNCT3_DIV, 5'd10, 5'd11, 5'd14, 32'hFFFF_FFF9, 32'd2);
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        check("midop reset data", alu_result_o, 32'd0);
        check("midop reset ctrl", {22'd0, mem_ctrl_o, wb_ctrl_o, rd_o}, 32'd0);
        check("midop reset stall", {31'd0, stall_o}, 32'd0);
        rst_n = 1'b1;
        md_run("divu after reset", FUNCT3_DIVU, 32'd100, 32'd7, 5'd12, 32'd14, 33);
        md_run("remu after reset", FUNCT3_REMU, 32'd100, 32'd7, 5'd12, 32'd2, 33);
        set_rtype(7'd0, FUNCT3_ADD, 5'd0, 5'd0, 5'd0, '0, '0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
